// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a stable, synchronized MMCM lock, then releases
// the MAC and AXI-Lite domains in order. It pulses the GTP soft reset and
// supervises GTP reset-done with a per-attempt timeout and bounded retries.
// Every output is a single flop whose value comes from the next state only.
module reset_sequencer #(
  parameter int LOCK_WAIT_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES = 64,
  parameter int GTP_RST_PULSE    = 16,
  parameter int GTP_TIMEOUT      = 65536,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 17
) (
  input  logic       clk,
  input  logic       g_reset_n,
  input  logic       dcm_locked,
  input  logic       gtp_reset_done,
  output logic       mac_rst_n,
  output logic       axi_rst_n,
  output logic       gtp_soft_reset,
  output logic       sys_ready,
  output logic       seq_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    HOLD, LOCK_WAIT, REL_MAC, REL_AXI, GTP_PULSE, GTP_WAIT, READY, FAIL
  } state_t;

  // Counter reload values. Each one is "duration - 1" because the counter
  // runs down to zero and the transition fires on the zero cycle.
  localparam logic [CNT_W-1:0] LOCK_LOAD    = CNT_W'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(GTP_RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(GTP_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lock_meta_q, lock_s_q;
  logic             done_meta_q, done_s_q;
  logic             mac_rst_n_d, axi_rst_n_d, gtp_soft_reset_d, sys_ready_d, seq_fail_d;
  logic [3:0]       retry_inc;
  logic             cnt_zero;

  assign cnt_zero  = (cnt_q == '0);
  assign retry_inc = retry_q + 4'd1;

  // Two-flop synchronizers for the asynchronous lock and reset-done inputs.
  always_ff @(posedge clk or negedge g_reset_n) begin
    if (!g_reset_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      done_meta_q <= 1'b0;
      done_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= dcm_locked;
      lock_s_q    <= lock_meta_q;
      done_meta_q <= gtp_reset_done;
      done_s_q    <= done_meta_q;
    end
  end

  // Next-state, counter and status-counter logic; lock loss overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (state_q != HOLD && !lock_s_q) begin
      state_d = HOLD;
      cnt_d   = '0;
      retry_d = 4'd0;
      if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end else begin
      case (state_q)
        HOLD: begin
          if (lock_s_q) begin
            state_d = LOCK_WAIT;
            cnt_d   = LOCK_LOAD;
          end
        end
        LOCK_WAIT: begin
          if (cnt_zero) begin
            state_d = REL_MAC;
            cnt_d   = GAP_LOAD;
          end else cnt_d = cnt_q - 1'b1;
        end
        REL_MAC: begin
          if (cnt_zero) begin
            state_d = REL_AXI;
            cnt_d   = GAP_LOAD;
          end else cnt_d = cnt_q - 1'b1;
        end
        REL_AXI: begin
          if (cnt_zero) begin
            state_d = GTP_PULSE;
            cnt_d   = PULSE_LOAD;
          end else cnt_d = cnt_q - 1'b1;
        end
        GTP_PULSE: begin
          if (cnt_zero) begin
            state_d = GTP_WAIT;
            cnt_d   = TIMEOUT_LOAD;
          end else cnt_d = cnt_q - 1'b1;
        end
        GTP_WAIT: begin
          // If done arrives on the timeout cycle, it wins over a retry.
          if (done_s_q) begin
            state_d = READY;
            cnt_d   = '0;
            retry_d = 4'd0;
          end else if (cnt_zero) begin
            retry_d = retry_inc;
            if (retry_inc < RETRY_LIMIT) begin
              state_d = GTP_PULSE;
              cnt_d   = PULSE_LOAD;
            end else begin
              state_d = FAIL;
            end
          end else cnt_d = cnt_q - 1'b1;
        end
        READY: begin
          // The GTP has dropped out of reset-done, so re-run only the GTP
          // stage. The MAC and AXI domains stay released.
          if (!done_s_q) begin
            state_d = GTP_PULSE;
            cnt_d   = PULSE_LOAD;
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = HOLD;
      endcase
    end
  end

  // Output decode from the next state, so that the output flops change on the same edge as the state.
  always_comb begin
    mac_rst_n_d      = !(state_d == HOLD || state_d == LOCK_WAIT);
    axi_rst_n_d      = !(state_d == HOLD || state_d == LOCK_WAIT || state_d == REL_MAC);
    gtp_soft_reset_d = (state_d == HOLD) || (state_d == LOCK_WAIT) ||
                       (state_d == GTP_PULSE) || (state_d == FAIL);
    sys_ready_d      = (state_d == READY);
    seq_fail_d       = (state_d == FAIL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge g_reset_n) begin
    if (!g_reset_n) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      retry_q        <= 4'd0;
      loss_q         <= 8'd0;
      mac_rst_n      <= 1'b0;
      axi_rst_n      <= 1'b0;
      gtp_soft_reset <= 1'b1;
      sys_ready      <= 1'b0;
      seq_fail       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      loss_q         <= loss_d;
      mac_rst_n      <= mac_rst_n_d;
      axi_rst_n      <= axi_rst_n_d;
      gtp_soft_reset <= gtp_soft_reset_d;
      sys_ready      <= sys_ready_d;
      seq_fail       <= seq_fail_d;
    end
  end

  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer, built with the reduced test timing.
// Edge numbers in comments count rising clk edges after reset release.
// Edge 1 is the first rising edge after the release.
// An input that is written after go_to(k) is first sampled on edge k+1.
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       g_reset_n = 1'b0;
  logic       dcm_locked = 1'b0;
  logic       gtp_reset_done = 1'b0;
  logic       mac_rst_n, axi_rst_n, gtp_soft_reset, sys_ready, seq_fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;

  reset_sequencer #(
    .LOCK_WAIT_CYCLES(8), .STAGE_GAP_CYCLES(4), .GTP_RST_PULSE(2),
    .GTP_TIMEOUT(16), .MAX_RETRY(3), .CNT_W(17)
  ) dut (
    .clk(clk), .g_reset_n(g_reset_n), .dcm_locked(dcm_locked),
    .gtp_reset_done(gtp_reset_done), .mac_rst_n(mac_rst_n), .axi_rst_n(axi_rst_n),
    .gtp_soft_reset(gtp_soft_reset), .sys_ready(sys_ready), .seq_fail(seq_fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Advance to 1 ns after rising edge n (counted from the last reset release).
  task automatic go_to(input int n);
    while (cyc - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for a few clocks and release it on a falling edge.
  task automatic do_reset();
    g_reset_n = 1'b0;
    dcm_locked = 1'b0;
    gtp_reset_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    g_reset_n = 1'b1;
    base = cyc;
  endtask

  task automatic test_reset();
    do_reset();
    go_to(2);
    checks++; if (mac_rst_n !== 1'b0) begin failures++; $display("FAIL rst_mac got=%b exp=0", mac_rst_n); end
    checks++; if (axi_rst_n !== 1'b0) begin failures++; $display("FAIL rst_axi got=%b exp=0", axi_rst_n); end
    checks++; if (gtp_soft_reset !== 1'b1) begin failures++; $display("FAIL rst_gtp got=%b exp=1", gtp_soft_reset); end
    checks++; if ({sys_ready, seq_fail} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {sys_ready, seq_fail}); end
    checks++; if ({retry_cnt, lock_loss_cnt} !== 12'h000) begin failures++; $display("FAIL rst_cnts got=%h exp=000", {retry_cnt, lock_loss_cnt}); end
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    do_reset();
    dcm_locked = 1'b1;            // edge2 lock_s=1, edge3 LOCK_WAIT, edge11 REL_MAC
    go_to(10);
    checks++; if (mac_rst_n !== 1'b0) begin failures++; $display("FAIL nom_mac_early got=%b exp=0", mac_rst_n); end
    go_to(11);
    checks++; if (mac_rst_n !== 1'b1) begin failures++; $display("FAIL nom_mac_rise got=%b exp=1", mac_rst_n); end
    checks++; if (axi_rst_n !== 1'b0) begin failures++; $display("FAIL nom_axi_early got=%b exp=0", axi_rst_n); end
    go_to(14);
    checks++; if (axi_rst_n !== 1'b0) begin failures++; $display("FAIL nom_axi_e14 got=%b exp=0", axi_rst_n); end
    go_to(15);
    checks++; if (axi_rst_n !== 1'b1) begin failures++; $display("FAIL nom_axi_rise got=%b exp=1", axi_rst_n); end
    checks++; if (gtp_soft_reset !== 1'b0) begin failures++; $display("FAIL nom_gtp_low got=%b exp=0", gtp_soft_reset); end
    go_to(18);
    checks++; if (gtp_soft_reset !== 1'b0) begin failures++; $display("FAIL nom_gtp_e18 got=%b exp=0", gtp_soft_reset); end
    go_to(19);
    checks++; if (gtp_soft_reset !== 1'b1) begin failures++; $display("FAIL nom_pulse_1 got=%b exp=1", gtp_soft_reset); end
    go_to(20);
    checks++; if (gtp_soft_reset !== 1'b1) begin failures++; $display("FAIL nom_pulse_2 got=%b exp=1", gtp_soft_reset); end
    go_to(21);
    checks++; if (gtp_soft_reset !== 1'b0) begin failures++; $display("FAIL nom_pulse_end got=%b exp=0", gtp_soft_reset); end
    go_to(26);
    gtp_reset_done = 1'b1;        // edge28 done_s=1, edge29 READY
    go_to(28);
    checks++; if (sys_ready !== 1'b0) begin failures++; $display("FAIL nom_ready_early got=%b exp=0", sys_ready); end
    go_to(29);
    checks++; if (sys_ready !== 1'b1) begin failures++; $display("FAIL nom_ready got=%b exp=1", sys_ready); end
    checks++; if (retry_cnt !== 4'd0) begin failures++; $display("FAIL nom_retry got=%0d exp=0", retry_cnt); end
    go_to(30);
    gtp_reset_done = 1'b0;        // edge32 done_s=0, edge33 GTP_PULSE
    go_to(33);
    checks++; if ({sys_ready, gtp_soft_reset, mac_rst_n, axi_rst_n} !== 4'b0111) begin
      failures++; $display("FAIL nom_done_drop got=%b exp=0111", {sys_ready, gtp_soft_reset, mac_rst_n, axi_rst_n}); end
    $display("test_nominal done");
  endtask

  task automatic test_lock_loss_ready();
    do_reset();
    dcm_locked = 1'b1;
    go_to(26);
    gtp_reset_done = 1'b1;        // READY at edge29
    go_to(31);
    dcm_locked = 1'b0;            // edge33 lock_s=0, edge34 HOLD (3 clk)
    go_to(33);
    checks++; if ({mac_rst_n, sys_ready} !== 2'b11) begin failures++; $display("FAIL ll_before got=%b exp=11", {mac_rst_n, sys_ready}); end
    go_to(34);
    checks++; if ({mac_rst_n, axi_rst_n, gtp_soft_reset, sys_ready} !== 4'b0010) begin
      failures++; $display("FAIL ll_ready got=%b exp=0010", {mac_rst_n, axi_rst_n, gtp_soft_reset, sys_ready}); end
    checks++; if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL ll_cnt got=%0d exp=1", lock_loss_cnt); end
    $display("test_lock_loss_ready done");
  endtask

  task automatic test_lock_glitch();
    do_reset();
    dcm_locked = 1'b1;            // LOCK_WAIT at edge3
    go_to(4);
    dcm_locked = 1'b0;            // edge6 lock_s=0, edge7 HOLD
    go_to(5);
    dcm_locked = 1'b1;            // edge7 lock_s=1, edge8 LOCK_WAIT, edge16 REL_MAC
    go_to(6);
    checks++; if (lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL gl_cnt0 got=%0d exp=0", lock_loss_cnt); end
    go_to(7);
    checks++; if (lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL gl_cnt1 got=%0d exp=1", lock_loss_cnt); end
    go_to(15);
    checks++; if (mac_rst_n !== 1'b0) begin failures++; $display("FAIL gl_mac_early got=%b exp=0", mac_rst_n); end
    go_to(16);
    checks++; if (mac_rst_n !== 1'b1) begin failures++; $display("FAIL gl_mac_rise got=%b exp=1", mac_rst_n); end
    $display("test_lock_glitch done");
  endtask

  task automatic test_gtp_fail();
    do_reset();
    dcm_locked = 1'b1;            // waits: 21..37, 39..55, 57..73
    go_to(36);
    checks++; if ({retry_cnt, gtp_soft_reset} !== 5'b0000_0) begin failures++; $display("FAIL gf_e36 got=%b exp=00000", {retry_cnt, gtp_soft_reset}); end
    go_to(37);
    checks++; if ({retry_cnt, gtp_soft_reset} !== 5'b0001_1) begin failures++; $display("FAIL gf_retry1 got=%b exp=00011", {retry_cnt, gtp_soft_reset}); end
    go_to(39);
    checks++; if (gtp_soft_reset !== 1'b0) begin failures++; $display("FAIL gf_pulse2_end got=%b exp=0", gtp_soft_reset); end
    go_to(55);
    checks++; if (retry_cnt !== 4'd2) begin failures++; $display("FAIL gf_retry2 got=%0d exp=2", retry_cnt); end
    go_to(72);
    checks++; if (seq_fail !== 1'b0) begin failures++; $display("FAIL gf_fail_early got=%b exp=0", seq_fail); end
    go_to(73);
    checks++; if ({retry_cnt, seq_fail, gtp_soft_reset, mac_rst_n, axi_rst_n} !== 8'b0011_1111) begin
      failures++; $display("FAIL gf_fail got=%b exp=00111111", {retry_cnt, seq_fail, gtp_soft_reset, mac_rst_n, axi_rst_n}); end
    go_to(80);
    checks++; if ({seq_fail, sys_ready} !== 2'b10) begin failures++; $display("FAIL gf_fail_stay got=%b exp=10", {seq_fail, sys_ready}); end
    $display("test_gtp_fail done");
  endtask

  task automatic test_timeout_edge();
    do_reset();
    dcm_locked = 1'b1;            // first wait counter hits 0 at edge36
    go_to(34);
    gtp_reset_done = 1'b1;        // edge36 done_s=1, seen with counter 0 at edge37
    go_to(36);
    checks++; if (sys_ready !== 1'b0) begin failures++; $display("FAIL te_early got=%b exp=0", sys_ready); end
    go_to(37);
    checks++; if ({sys_ready, retry_cnt, gtp_soft_reset} !== 6'b1_0000_0) begin
      failures++; $display("FAIL te_ready got=%b exp=100000", {sys_ready, retry_cnt, gtp_soft_reset}); end
    $display("test_timeout_edge done");
  endtask

  task automatic test_async_reset();
    do_reset();
    dcm_locked = 1'b1;
    go_to(25);                    // in GTP_WAIT
    #2;
    g_reset_n = 1'b0;             // mid-cycle, no clock edge before the check
    #1;
    checks++; if ({mac_rst_n, axi_rst_n, gtp_soft_reset, sys_ready, seq_fail} !== 5'b00100) begin
      failures++; $display("FAIL ar_outs got=%b exp=00100", {mac_rst_n, axi_rst_n, gtp_soft_reset, sys_ready, seq_fail}); end
    checks++; if ({retry_cnt, lock_loss_cnt} !== 12'h000) begin failures++; $display("FAIL ar_cnts got=%h exp=000", {retry_cnt, lock_loss_cnt}); end
    $display("test_async_reset done");
  endtask

  task automatic test_loss_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      dcm_locked = 1'b1;          // LOCK_WAIT three edges later
      repeat (3) begin @(posedge clk); #1; end
      dcm_locked = 1'b0;          // HOLD three edges later
      repeat (3) begin @(posedge clk); #1; end
      if (i == 9) begin
        checks++; if (lock_loss_cnt !== 8'd10) begin failures++; $display("FAIL sat_cnt10 got=%0d exp=10", lock_loss_cnt); end
      end
    end
    checks++; if (lock_loss_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt255 got=%0d exp=255", lock_loss_cnt); end
    $display("test_loss_saturate done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_ready();
    test_lock_glitch();
    test_gtp_fail();
    test_timeout_edge();
    test_async_reset();
    test_loss_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
